// File: rtl/matrix_scan_capture_if.sv
// Pin-side bundle for the LED-matrix scan capture block.
// The slave modport is the capture block; the master modport is whatever drives the display pins and reads the frame.
interface matrix_scan_capture_if #(
  parameter int gs = 8
);
  logic [gs-1:0]    row_val_i;
  logic [gs-1:0]    col_val_i;
  logic [gs*gs-1:0] matrix_o;
  logic             frame_valid_o;
  logic             busy_o;
  logic             err_o;
  logic [7:0]       frame_cnt_o;

  modport slave (
    input  row_val_i,
    input  col_val_i,
    output matrix_o,
    output frame_valid_o,
    output busy_o,
    output err_o,
    output frame_cnt_o
  );

  modport master (
    output row_val_i,
    output col_val_i,
    input  matrix_o,
    input  frame_valid_o,
    input  busy_o,
    input  err_o,
    input  frame_cnt_o
  );
endinterface

// File: rtl/matrix_scan_capture.sv
// Rebuilds gs x gs LED-matrix frames from the active-low row-strobe / column stream and publishes each complete frame atomically.
// Define MATRIX_SCAN_CAPTURE_SYNC_EN to put a two-flop synchronizer on the pin inputs (+2 cycles on every output).
//
// state | meaning
// IDLE  | waiting for a row-0 strobe to start a frame
// CAP   | capturing rows 1..gs-1 in order into the shadow buffer
module matrix_scan_capture #(
  parameter int gs = 8
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  matrix_scan_capture_if.slave  bus
);

  localparam int EW = (gs > 2) ? $clog2(gs) : 1;
  localparam logic [EW-1:0] LAST_ROW = EW'(gs - 1);
  localparam logic [EW-1:0] ROW_ONE  = EW'(1);
  localparam logic [gs-1:0] HOT_ROW0 = {{(gs-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    CAP  = 1'b1
  } state_t;

  logic [gs-1:0] w_row;
  logic [gs-1:0] w_col;

`ifdef MATRIX_SCAN_CAPTURE_SYNC_EN
  logic [gs-1:0] r_row_s1;
  logic [gs-1:0] r_row_s2;
  logic [gs-1:0] r_col_s1;
  logic [gs-1:0] r_col_s2;

  // Row synchronizer resets to all-ones so the decoder sees an idle display.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_row_s1 <= '1;
      r_row_s2 <= '1;
      r_col_s1 <= '0;
      r_col_s2 <= '0;
    end else begin
      r_row_s1 <= bus.row_val_i;
      r_row_s2 <= r_row_s1;
      r_col_s1 <= bus.col_val_i;
      r_col_s2 <= r_col_s1;
    end
  end

  assign w_row = r_row_s2;
  assign w_col = r_col_s2;
`else
  assign w_row = bus.row_val_i;
  assign w_col = bus.col_val_i;
`endif

  state_t           r_state;
  state_t           w_state_nxt;
  logic [EW-1:0]    r_exp;
  logic [EW-1:0]    w_exp_nxt;
  logic [gs*gs-1:0] r_shadow;
  logic [gs*gs-1:0] w_shadow_nxt;
  logic [gs*gs-1:0] r_matrix;
  logic [gs*gs-1:0] w_matrix_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_nxt;

  logic [gs-1:0]    w_strobe;
  logic [gs-1:0]    w_exp_hot;
  logic             w_row0;
  logic             w_is_exp;

  assign w_strobe = ~w_row;
  assign w_row0   = (w_strobe == HOT_ROW0);
  assign w_is_exp = (w_strobe == w_exp_hot);

  always_comb begin
    w_exp_hot = '0;
    w_exp_hot[r_exp] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Exact match against the expected row covers zero, wrong-row and multi-row strobes in one compare.
  always_comb begin
    w_state_nxt  = r_state;
    w_exp_nxt    = r_exp;
    w_shadow_nxt = r_shadow;
    w_matrix_nxt = r_matrix;
    w_valid_nxt  = 1'b0;
    w_err_nxt    = r_err;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_row0) begin
          w_shadow_nxt[gs-1:0] = w_col;
          w_exp_nxt            = ROW_ONE;
          w_err_nxt            = 1'b0;
          w_state_nxt          = CAP;
        end
      end
      CAP: begin
        if (w_is_exp) begin
          for (int r = 0; r < gs; r++) begin
            if (w_exp_hot[r]) begin
              w_shadow_nxt[r*gs +: gs] = w_col;
            end
          end
          if (r_exp == LAST_ROW) begin
            w_matrix_nxt = w_shadow_nxt;
            w_valid_nxt  = 1'b1;
            w_cnt_nxt    = r_cnt + 8'd1;
            w_exp_nxt    = '0;
            w_state_nxt  = IDLE;
          end else begin
            w_exp_nxt = r_exp + ROW_ONE;
          end
        end else if (w_row0) begin
          // Resync restarts the frame but keeps the error visible.
          w_shadow_nxt[gs-1:0] = w_col;
          w_exp_nxt            = ROW_ONE;
          w_err_nxt            = 1'b1;
        end else begin
          w_err_nxt   = 1'b1;
          w_exp_nxt   = '0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_exp_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_exp    <= '0;
      r_shadow <= '0;
      r_matrix <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      r_exp    <= w_exp_nxt;
      r_shadow <= w_shadow_nxt;
      r_matrix <= w_matrix_nxt;
      r_valid  <= w_valid_nxt;
      r_err    <= w_err_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.matrix_o      = r_matrix;
  assign bus.frame_valid_o = r_valid;
  assign bus.busy_o        = (r_state == CAP);
  assign bus.err_o         = r_err;
  assign bus.frame_cnt_o   = r_cnt;

endmodule

// File: tb/tb_matrix_scan_capture.sv
// Self-checking bench for matrix_scan_capture: a vector table for single-frame protocol cases,
// hand sequences for resync, reset and back-to-back frames, and a frame scoreboard on frame_valid_o.
module tb_matrix_scan_capture;
  localparam int GS = 8;
`ifdef MATRIX_SCAN_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  matrix_scan_capture_if #(.gs(GS)) bus ();
  matrix_scan_capture #(.gs(GS)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  typedef struct {
    logic [7:0]  row;
    logic [7:0]  col;
    logic        v;
    logic        e;
    logic        b;
    logic        cm;
    logic        push;
    logic [63:0] m;
  } vec_t;

  typedef struct {
    logic        v;
    logic        e;
    logic        b;
    logic        cm;
    logic [63:0] m;
    int          id;
  } pend_t;

  typedef struct {
    logic [63:0] m;
    logic [7:0]  cnt;
  } frm_t;

  vec_t  tbl[$];
  pend_t pend[$];
  frm_t  sb[$];
  int n_cmp   = 0;
  int n_err   = 0;
  int n_pulse = 0;
  int step_no = 0;
  logic [7:0] exp_cnt = 8'd0;

  localparam logic [63:0] F1 = 64'h8040201008040201;
  localparam logic [63:0] F2 = 64'h0F0F0F0F0F0F0F0F;
  localparam logic [63:0] FA = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] F5 = 64'h5555555555555555;

  function automatic logic [7:0] rs(input int r);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << r);
  endfunction

  task automatic chk(input string name, input int id, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] row, input logic [7:0] col, input logic v,
                              input logic e, input logic b, input logic cm = 1'b0,
                              input logic push = 1'b0, input logic [63:0] m = 64'd0);
    vec_t t;
    t = '{row, col, v, e, b, cm, push, m};
    tbl.push_back(t);
  endfunction

  // Drives one cycle; expectations describe the outputs after that edge and are checked LAT edges later.
  task automatic step(input logic [7:0] row, input logic [7:0] col, input logic v, input logic e,
                      input logic b, input logic cm = 1'b0, input logic push = 1'b0,
                      input logic [63:0] m = 64'd0);
    pend_t p;
    frm_t  f;
    step_no++;
    if (push) begin
      exp_cnt = exp_cnt + 8'd1;
      f = '{m, exp_cnt};
      sb.push_back(f);
    end
    bus.row_val_i = row;
    bus.col_val_i = col;
    @(posedge clk_i);
    #1;
    p = '{v, e, b, cm, m, step_no};
    pend.push_back(p);
    if (pend.size() > LAT) begin
      p = pend.pop_front();
      chk("frame_valid", p.id, 64'(bus.frame_valid_o), 64'(p.v));
      chk("err", p.id, 64'(bus.err_o), 64'(p.e));
      chk("busy", p.id, 64'(bus.busy_o), 64'(p.b));
      if (p.cm) chk("matrix_hold", p.id, bus.matrix_o, p.m);
    end
  endtask

  task automatic flush(input logic e);
    repeat (LAT) step(8'hFF, 8'h00, 1'b0, e, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_matrix"}, step_no, bus.matrix_o, 64'd0);
    chk({tag, "_valid"}, step_no, 64'(bus.frame_valid_o), 64'd0);
    chk({tag, "_busy"}, step_no, 64'(bus.busy_o), 64'd0);
    chk({tag, "_err"}, step_no, 64'(bus.err_o), 64'd0);
    chk({tag, "_cnt"}, step_no, 64'(bus.frame_cnt_o), 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("rst");
    pend.delete();
    chk("rst_sb_empty", step_no, 64'(sb.size()), 64'd0);
    sb.delete();
    exp_cnt = 8'd0;
    @(posedge clk_i);
    #1;
    chk("rst_hold_matrix", step_no, bus.matrix_o, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  always @(negedge clk_i) begin : mon
    frm_t f;
    if (rst_ni && bus.frame_valid_o === 1'b1) begin
      n_pulse++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_frame: got matrix %0h expected no frame", bus.matrix_o);
      end else begin
        f = sb.pop_front();
        chk("frame_matrix", step_no, bus.matrix_o, f.m);
        chk("frame_cnt", step_no, 64'(bus.frame_cnt_o), 64'(f.cnt));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] fm;
    logic [7:0]  c;
    int p0;

    bus.row_val_i = 8'hFF;
    bus.col_val_i = 8'h00;

    // full frame, then idle-state noise
    for (int r = 0; r < 7; r++) add(rs(r), 8'h01 << r, 1'b0, 1'b0, 1'b1);
    add(rs(7), 8'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, F1);
    add(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, F1);
    add(rs(3), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, F1);
    add(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, F1);
    // abort mid-frame
    for (int r = 0; r < 4; r++) add(rs(r), 8'hFF, 1'b0, 1'b0, 1'b1);
    add(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, F1);
    add(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, F1);
    // clean frame clears the error at row 0
    for (int r = 0; r < 7; r++) add(rs(r), 8'h0F, 1'b0, 1'b0, 1'b1);
    add(rs(7), 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, F2);
    // wrong order
    add(rs(0), 8'h33, 1'b0, 1'b0, 1'b1);
    add(rs(2), 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, F2);
    add(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, F2);
    add(rs(1), 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, F2);
    // multiple rows low
    add(rs(0), 8'h33, 1'b0, 1'b0, 1'b1);
    add(8'hF9, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, F2);

    #1;
    check_reset_outputs("init");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].row, tbl[i].col, tbl[i].v, tbl[i].e, tbl[i].b, tbl[i].cm, tbl[i].push, tbl[i].m);
    end

    // resync: row 0 again after row 4
    for (int r = 0; r < 5; r++) step(rs(r), 8'h11, 1'b0, 1'b0, 1'b1);
    step(rs(0), 8'hAA, 1'b0, 1'b1, 1'b1);
    for (int r = 1; r < 7; r++) step(rs(r), 8'hAA, 1'b0, 1'b1, 1'b1);
    step(rs(7), 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, FA);
    step(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, FA);
    flush(1'b1);

    // reset during row 5
    for (int r = 0; r < 5; r++) step(rs(r), 8'h33, 1'b0, 1'b0, 1'b1);
    bus.row_val_i = rs(5);
    bus.col_val_i = 8'h33;
    do_reset();
    for (int r = 0; r < 7; r++) step(rs(r), 8'h55, 1'b0, 1'b0, 1'b1);
    step(rs(7), 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, F5);
    step(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, F5);
    flush(1'b0);
    chk("cnt_after_reset_frame", step_no, 64'(bus.frame_cnt_o), 64'd1);

    // 256 back-to-back frames from a fresh count
    do_reset();
    p0 = n_pulse;
    for (int f = 0; f < 256; f++) begin
      fm = 64'd0;
      for (int r = 0; r < 8; r++) begin
        c = 8'(f * 7 + r * 13);
        fm[r*8 +: 8] = c;
        if (r < 7) step(rs(r), c, 1'b0, 1'b0, 1'b1);
        else       step(rs(r), c, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, fm);
      end
    end
    repeat (LAT + 1) step(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("b2b_pulses", step_no, 64'(n_pulse - p0), 64'd256);
    chk("b2b_cnt_wrap", step_no, 64'(bus.frame_cnt_o), 64'd0);
    chk("sb_drained", step_no, 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/matrix_scan_capture.md
Name: matrix_scan_capture

Overview:
- Receive end of the 8x8 LED-matrix scan interface; rebuilds the full frame from the row-strobe / column-value stream the display driver emits.
- Samples the active-low one-cold row strobe plus column bits, assembles rows in a shadow buffer, then publishes the complete frame atomically.
- Sits on the display pins in self-check and loopback configurations; its frame output uses the same packing as the display driver's matrix input.

Parameters:
- gs, 8, grid size; rows = columns = gs (gs >= 2).

Ports:
- clk_i  input  1  system clock, rising edge
- rst_ni  input  1  asynchronous active-low reset
- row_val_i  input  gs  row strobes, active-low; exactly one bit low = that row driven; all high = display idle
- col_val_i  input  gs  column values of the currently strobed row, active-high
- matrix_o  output  gs*gs  last complete frame; bit gs*r+c = row r, column c
- frame_valid_o  output  1  one-cycle pulse when matrix_o has just been updated
- busy_o  output  1  high while a frame is being captured
- err_o  output  1  sticky protocol-error flag; cleared when the next frame starts
- frame_cnt_o  output  8  count of completed frames, wraps 255->0

Behaviour:
- Reset (rst_ni low, asynchronous): matrix_o=0, shadow=0, frame_valid_o=0, busy_o=0, err_o=0, frame_cnt_o=0, expected row=0, state IDLE. Reset mid-capture discards the partial frame; matrix_o still returns to 0.
- Decode: strobe = ~row_val_i. It is a legal row strobe only when one-hot.
- IDLE:
  - strobe = one-hot bit0: write shadow row 0 <- col_val_i; expected=1; err_o<=0; enter CAP; busy_o=1 from next cycle.
  - Any other value: stay in IDLE; no error. This is the wait for frame start.
- CAP, one row per cycle:
  - strobe = one-hot(expected), expected < gs-1: write shadow row; expected++.
  - strobe = one-hot(expected), expected = gs-1: matrix_o <= shadow with the final row merged in the same edge; frame_valid_o=1 for one cycle; frame_cnt_o++; enter IDLE.
  - strobe = 0 (display disabled mid-frame): abort; err_o<=1; enter IDLE; matrix_o unchanged.
  - strobe = one-hot bit0 (resync): err_o<=1; restart as in IDLE row 0 but keep err_o=1. The restart does not clear err_o.
  - Any other value (wrong row, or multiple rows low): err_o<=1; enter IDLE; matrix_o unchanged.
- Latency: final row sampled at edge N -> matrix_o and frame_valid_o change at edge N.
- Inputs are sampled every cycle, with no enable. The source presents one row per clk_i cycle.
- matrix_o never shows a partial frame; only a complete ordered sequence 0..gs-1 updates it.
- Back-to-back: a row-0 strobe in the cycle right after completion starts a new frame with no gap cycle.
- err_o clears only on a clean IDLE->CAP row-0 start.
- frame_cnt_o is 8-bit modulo arithmetic.

Optional Feature:
- Macro: MATRIX_SCAN_CAPTURE_SYNC_EN.
- Defined:
  - row_val_i and col_val_i each pass through a two-flop synchronizer before decode.
  - Every output gains +2 cycles latency.
  - Synchronizer flops reset to all-ones (row) and zero (col).
- Undefined: inputs feed the decoder directly, with the latency given above.

Test Plan:
- Full frame: row-0 strobe, then rows 1..7 in consecutive cycles; row r has col=8'h01<<r -> frame_valid_o pulses once in the last-row cycle; matrix_o=64'h8040201008040201; frame_cnt_o=1; err_o=0.
- Abort: rows 0..3 with col=8'hFF, then row_val_i=8'hFF -> err_o=1; no frame_valid_o; matrix_o keeps its previous value. A following clean frame clears err_o at its row 0.
- Wrong order / multi-row:
  - Row 0, then row 2 -> err_o=1; state IDLE.
  - Separately: row 0, then row_val_i=8'hF9 -> err_o=1; matrix_o unchanged.
- Resync: rows 0..4, then row 0 again, then rows 1..7 with col=8'hAA -> err_o=1 stays set; one frame_valid_o; matrix_o = all rows 8'hAA.
- Reset mid-capture: rst_ni low during row 5, release, then a full frame of col=8'h55 -> outputs 0 during reset; after the frame, matrix_o=64'h5555555555555555; frame_cnt_o=1.
- Back-to-back: 256 consecutive frames with no gap cycles -> 256 frame_valid_o pulses; frame_cnt_o wraps to 0. With MATRIX_SCAN_CAPTURE_SYNC_EN, each pulse is 2 cycles later.
